// File: rtl/yee_sub2_pixel_avg_pkg.sv
// Shared types and constants for the 2:1 pixel averaging block.
package yee_pkg;

  localparam int PIX_CH_W = 8;

  // One RGB pixel; r occupies the top byte, b the bottom byte.
  typedef struct packed {
    logic [PIX_CH_W-1:0] r;
    logic [PIX_CH_W-1:0] g;
    logic [PIX_CH_W-1:0] b;
  } pixel24_t;

  localparam pixel24_t PIX_ZERO = 24'h000000;

  // Pairing FSM: nothing held, first pixel held, averaged pixel on output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pair_state_t;

endpackage

// File: rtl/yee_sub2_pixel_avg_if.sv
// Pixel stream interface of yee_sub2_pixel_avg: upstream push side,
// downstream averaged side, flush and status.
interface yee_sub2_pixel_avg_if #(
  parameter int DEPTH = 4
) ();
  import yee_pkg::*;

  pixel24_t                   sub1_to_sub2;
  logic                       sub1_to_sub2_vld;
  logic                       sub2_rdy;
  logic                       flush;
  pixel24_t                   sub2_out_pixel;
  logic                       sub2_out_vld;
  logic                       out_rdy;
  logic [$clog2(DEPTH):0]     fifo_cnt;
  logic                       ovf_sticky;

  // Environment side: drives pixels, flush and downstream ready.
  modport master (
    output sub1_to_sub2, sub1_to_sub2_vld, flush, out_rdy,
    input  sub2_rdy, sub2_out_pixel, sub2_out_vld, fifo_cnt, ovf_sticky
  );

  // Block side.
  modport slave (
    input  sub1_to_sub2, sub1_to_sub2_vld, flush, out_rdy,
    output sub2_rdy, sub2_out_pixel, sub2_out_vld, fifo_cnt, ovf_sticky
  );
endinterface

// File: rtl/yee_sub2_pixel_avg_fifo.sv
// yee_pixel_fifo: first-word-fall-through pixel FIFO with synchronous flush.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module yee_pixel_fifo
  import yee_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   cp,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  pixel24_t               wr_data,
  output pixel24_t               rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pixel24_t        mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  // Qualify push/pop against occupancy; flush overrides both.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    do_push_s = push & ~full & ~flush;
    do_pop_s  = pop & ~empty & ~flush;
  end

  // Storage write; contents are only observed after a push so no reset is needed.
  always_ff @(posedge cp) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

endmodule

// File: rtl/yee_sub2_pixel_avg.sv
// yee_sub2_pixel_avg: averages consecutive pixel pairs per channel, halving
// the pixel rate. Optional macro YEE_SUB2_ROUND_EN selects round-half-up
// averaging; without it the average truncates.
module yee_sub2_pixel_avg
  import yee_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 cp,
  input  logic                 reset,
  yee_sub2_pixel_avg_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Per-channel average; a 9-bit sum cannot overflow so the result fits 8 bits.
  function automatic logic [PIX_CH_W-1:0] avg_ch(input logic [PIX_CH_W-1:0] a,
                                                 input logic [PIX_CH_W-1:0] b);
    logic [PIX_CH_W:0] sum;
`ifdef YEE_SUB2_ROUND_EN
    sum = {1'b0, a} + {1'b0, b} + {{PIX_CH_W{1'b0}}, 1'b1};
`else
    sum = {1'b0, a} + {1'b0, b};
`endif
    return sum[PIX_CH_W:1];
  endfunction

  function automatic pixel24_t avg_pix(input pixel24_t a, input pixel24_t b);
    pixel24_t res;
    res.r = avg_ch(a.r, b.r);
    res.g = avg_ch(a.g, b.g);
    res.b = avg_ch(a.b, b.b);
    return res;
  endfunction

  pixel24_t      head_s;
  logic [CW-1:0] cnt_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  pair_state_t   state_r;
  pixel24_t      first_r;
  pixel24_t      out_pixel_r;
  logic          out_vld_r;
  logic          ovf_r;

  yee_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .cp      (cp),
    .reset   (reset),
    .flush   (bus.flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (bus.sub1_to_sub2),
    .rd_data (head_s),
    .count   (cnt_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Handshake decode: the FSM takes a pixel whenever it has room for one.
  always_comb begin
    push_s = bus.sub1_to_sub2_vld & ~full_s;
    case (state_r)
      EMPTY:   pop_s = ~empty_s;
      HALF:    pop_s = ~empty_s;
      FULL:    pop_s = ~empty_s & bus.out_rdy;
      default: pop_s = 1'b0;
    endcase
  end

  // Pairing FSM: latch first pixel, average with second, hold until accepted.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      state_r     <= EMPTY;
      first_r     <= PIX_ZERO;
      out_pixel_r <= PIX_ZERO;
      out_vld_r   <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= EMPTY;
      first_r     <= PIX_ZERO;
      out_pixel_r <= PIX_ZERO;
      out_vld_r   <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (!empty_s) begin
            first_r <= head_s;
            state_r <= HALF;
          end
        end
        HALF: begin
          if (!empty_s) begin
            out_pixel_r <= avg_pix(first_r, head_s);
            out_vld_r   <= 1'b1;
            state_r     <= FULL;
          end
        end
        FULL: begin
          if (bus.out_rdy) begin
            out_vld_r <= 1'b0;
            if (!empty_s) begin
              first_r <= head_s;
              state_r <= HALF;
            end else begin
              state_r <= EMPTY;
            end
          end
        end
        default: begin
          state_r   <= EMPTY;
          out_vld_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag: a pixel offered while the FIFO is full.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (bus.flush) begin
      ovf_r <= 1'b0;
    end else if (bus.sub1_to_sub2_vld && full_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign bus.sub2_rdy       = ~full_s;
  assign bus.fifo_cnt       = cnt_s;
  assign bus.sub2_out_pixel = out_pixel_r;
  assign bus.sub2_out_vld   = out_vld_r;
  assign bus.ovf_sticky     = ovf_r;

endmodule

// File: tb/tb_yee_sub2_pixel_avg.sv
// Self-checking bench for yee_sub2_pixel_avg: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
module tb_yee_sub2_pixel_avg;
  localparam int DEPTH = 4;
`ifdef YEE_SUB2_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic cp = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  yee_sub2_pixel_avg_if #(.DEPTH(DEPTH)) bus ();

  yee_sub2_pixel_avg #(.DEPTH(DEPTH)) dut (
    .cp    (cp),
    .reset (reset),
    .bus   (bus)
  );

  always #5 cp = ~cp;

  // Reference model state.
  logic [23:0] m_fifo[$];
  bit          m_held_v;
  logic [23:0] m_held;
  bit          m_out_v;
  logic [23:0] m_out;
  bit          m_ovf;
  int          cyc = 0;
  int          n_taken = 0;
  int          taken_cyc[$];
  int          max_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_avg(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r;
    int ca, cb;
    r = 24'h0;
    for (int ch = 0; ch < 3; ch++) begin
      ca = int'((a >> (8 * ch)) & 24'hFF);
      cb = int'((b >> (8 * ch)) & 24'hFF);
      r  = r | (24'((ca + cb + RND) / 2) << (8 * ch));
    end
    return r;
  endfunction

  function automatic void model_clear();
    m_fifo.delete();
    m_held_v = 1'b0;
    m_out_v  = 1'b0;
    m_ovf    = 1'b0;
  endfunction

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit vld, input logic [23:0] pix, input bit ordy, input bit fl);
    bit          push, take;
    logic [23:0] p;
    bus.sub1_to_sub2_vld = vld;
    bus.sub1_to_sub2     = pix;
    bus.out_rdy          = ordy;
    bus.flush            = fl;
    if (bus.sub2_out_vld === 1'b1 && ordy && !fl) begin
      n_taken++;
      taken_cyc.push_back(cyc);
    end
    if (fl) begin
      model_clear();
    end else begin
      push = vld && (m_fifo.size() < DEPTH);
      if (vld && !push) m_ovf = 1'b1;
      take = (m_fifo.size() > 0) && (!m_out_v || ordy);
      if (m_out_v && ordy) m_out_v = 1'b0;
      if (take) begin
        p = m_fifo.pop_front();
        if (m_held_v) begin
          m_out    = ref_avg(m_held, p);
          m_out_v  = 1'b1;
          m_held_v = 1'b0;
        end else begin
          m_held   = p;
          m_held_v = 1'b1;
        end
      end
      if (push) m_fifo.push_back(pix);
    end
    @(posedge cp);
    #1;
    cyc++;
    if (int'(bus.fifo_cnt) > max_cnt) max_cnt = int'(bus.fifo_cnt);
    chk("vld", bus.sub2_out_vld, m_out_v);
    chk("cnt", bus.fifo_cnt, m_fifo.size());
    chk("rdy", bus.sub2_rdy, (m_fifo.size() < DEPTH) ? 1 : 0);
    chk("ovf", bus.ovf_sticky, m_ovf);
    if (m_out_v) chk("pix", bus.sub2_out_pixel, m_out);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, 24'h0, ordy, 1'b0);
  endtask

  // Hold reset low for one cycle, check reset outputs, release off-edge.
  task automatic do_reset();
    bus.sub1_to_sub2_vld = 1'b0;
    bus.flush            = 1'b0;
    reset = 1'b0;
    #2;
    model_clear();
    chk("rst_vld", bus.sub2_out_vld, 0);
    chk("rst_pix", bus.sub2_out_pixel, 24'h0);
    chk("rst_cnt", bus.fifo_cnt, 0);
    chk("rst_rdy", bus.sub2_rdy, 1);
    chk("rst_ovf", bus.ovf_sticky, 0);
    @(posedge cp);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [23:0] a, b, x;
    logic [23:0] pv[7];
    bus.sub1_to_sub2_vld = 1'b0;
    bus.sub1_to_sub2     = 24'h0;
    bus.out_rdy          = 1'b0;
    bus.flush            = 1'b0;

    do_reset();

    // Basic pair with fixed two-cycle latency.
    cycle(1'b1, 24'h102030, 1'b1, 1'b0);
    cycle(1'b1, 24'h304050, 1'b1, 1'b0);
    chk("lat_early_vld", bus.sub2_out_vld, 0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0);
    chk("lat_vld", bus.sub2_out_vld, 1);
    chk("avg_basic", bus.sub2_out_pixel, 24'h203040);
    idle(2, 1'b1);

    // Rounding boundary.
    cycle(1'b1, 24'hFF0001, 1'b1, 1'b0);
    cycle(1'b1, 24'hFF0100, 1'b1, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0);
`ifdef YEE_SUB2_ROUND_EN
    chk("avg_round", bus.sub2_out_pixel, 24'hFF0101);
`else
    chk("avg_round", bus.sub2_out_pixel, 24'hFF0000);
`endif
    idle(2, 1'b1);

    // Backpressure: fill FIFO behind a held output, then overflow.
    for (int i = 0; i < 7; i++) pv[i] = 24'($urandom);
    n_taken = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, pv[i], 1'b0, 1'b0);
    chk("bp_cnt_full", bus.fifo_cnt, DEPTH);
    chk("bp_rdy_low", bus.sub2_rdy, 0);
    chk("bp_ovf_clear", bus.ovf_sticky, 0);
    cycle(1'b1, pv[6], 1'b0, 1'b0);
    chk("bp_ovf_set", bus.ovf_sticky, 1);
    chk("bp_hold_pix", bus.sub2_out_pixel, ref_avg(pv[0], pv[1]));
    idle(3, 1'b0);
    chk("bp_hold_pix2", bus.sub2_out_pixel, ref_avg(pv[0], pv[1]));
    idle(12, 1'b1);
    chk("bp_drained", n_taken, 3);
    cycle(1'b0, 24'h0, 1'b1, 1'b1);
    chk("flush_ovf", bus.ovf_sticky, 0);

    // Streaming: 16 back-to-back pixels, one output every second cycle.
    n_taken = 0;
    max_cnt = 0;
    taken_cyc.delete();
    for (int i = 0; i < 22; i++) cycle(i < 16, 24'($urandom), 1'b1, 1'b0);
    chk("stream_n_out", n_taken, 8);
    chk("stream_cnt_le1", (max_cnt <= 1) ? 1 : 0, 1);
    for (int i = 1; i < taken_cyc.size(); i++)
      chk("stream_spacing", taken_cyc[i] - taken_cyc[i-1], 2);

    // Flush discards a held first pixel.
    x = 24'($urandom); a = 24'($urandom); b = 24'($urandom);
    n_taken = 0;
    cycle(1'b1, x, 1'b1, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b1);
    cycle(1'b1, a, 1'b1, 1'b0);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0);
    chk("flush_pair", bus.sub2_out_pixel, ref_avg(a, b));
    idle(4, 1'b1);
    chk("flush_n_out", n_taken, 1);

    // Reset discards a held first pixel.
    x = 24'($urandom); a = 24'($urandom); b = 24'($urandom);
    cycle(1'b1, x, 1'b1, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0);
    do_reset();
    n_taken = 0;
    cycle(1'b1, a, 1'b1, 1'b0);
    cycle(1'b1, b, 1'b1, 1'b0);
    cycle(1'b0, 24'h0, 1'b1, 1'b0);
    chk("reset_pair", bus.sub2_out_pixel, ref_avg(a, b));
    idle(4, 1'b1);
    chk("reset_n_out", n_taken, 1);

    // Random traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle(($urandom % 4) != 0, 24'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
    end
    idle(12, 1'b1);
    chk("final_empty", bus.fifo_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yee_sub2_pixel_avg.md
YEE_SUB2_PIXEL_AVG -- requirements
Module: yee_sub2_pixel_avg

Interface
REQ-001 Parameter DEPTH, default 4, sets the input FIFO entry count; it SHALL be a power of two and at least 2.
REQ-002 cp  input  1  clock; all state SHALL be updated on its rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-low.
REQ-004 sub1_to_sub2  input  24 (pixel24_t)  upstream pixel, R[23:16] G[15:8] B[7:0].
REQ-005 sub1_to_sub2_vld  input  1  upstream pixel valid.
REQ-006 sub2_rdy  output  1  FIFO can accept; SHALL equal (count < DEPTH).
REQ-007 flush  input  1  synchronous clear of FIFO and pairing state.
REQ-008 sub2_out_pixel  output  24 (pixel24_t)  averaged pixel.
REQ-009 sub2_out_vld  output  1  averaged pixel valid.
REQ-010 out_rdy  input  1  downstream accept.
REQ-011 fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 ovf_sticky  output  1  set when a pixel is offered (vld=1) while sub2_rdy=0; cleared only by reset or flush.

Function
REQ-013 Push SHALL occur when sub1_to_sub2_vld && sub2_rdy; pop SHALL occur when the FIFO is non-empty and the FSM takes a pixel.
REQ-014 Simultaneous push and pop on a full FIFO SHALL NOT be permitted, because sub2_rdy=0 when full; a simultaneous push and pop in any other state SHALL leave the count unchanged.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; data SHALL leave in arrival order.
REQ-016 The pairing FSM SHALL have states EMPTY, HALF and FULL.
REQ-017 EMPTY SHALL pop and go to HALF if the FIFO is non-empty, latching the pixel as the first pixel of the pair.
REQ-018 HALF SHALL pop and go to FULL if the FIFO is non-empty, registering the per-channel average of the first and second pixels into sub2_out_pixel.
REQ-019 In FULL, sub2_out_vld SHALL be 1.
REQ-020 FULL with out_rdy=1 and the FIFO non-empty SHALL pop and go to HALF, latching a new first pixel.
REQ-021 FULL with out_rdy=1 and the FIFO empty SHALL go to EMPTY.
REQ-022 FULL with out_rdy=0 SHALL hold state and sub2_out_pixel stable.
REQ-023 Average arithmetic SHALL be per 8-bit channel using a 9-bit sum, with result = sum[8:1] (truncate) or (sum+1)[8:1] (see REQ-031); the result SHALL never exceed 8'hFF.
REQ-024 Latency SHALL be two cycles from the push of the second pixel of a pair to sub2_out_vld=1, with an empty FIFO and the FSM in HALF.
REQ-025 Sustained throughput SHALL be one output per two input pixels with no bubbles while out_rdy=1.
REQ-026 flush SHALL take priority over push and pop in the same cycle: the FIFO empties, the FSM goes to EMPTY, sub2_out_vld=0, and ovf_sticky clears.

Reset
REQ-027 While reset=0, outputs SHALL be: sub2_out_vld=0, sub2_out_pixel=24'h0, fifo_cnt=0, sub2_rdy=1, ovf_sticky=0.
REQ-028 While reset=0, the FSM SHALL be in EMPTY and the pointers SHALL be 0.
REQ-029 Reset asserted mid-pair or mid-output SHALL discard the held first pixel and pending output, with no partial output after release.
REQ-030 The first push SHALL be accepted on the first rising edge after reset release.

Configuration
REQ-031 Macro YEE_SUB2_ROUND_EN:
- Defined: average = (a+b+1)>>1 per channel (round half up).
- Undefined: average = (a+b)>>1 (truncate).
- No other behaviour SHALL change.

Structure
REQ-032 Shared package yee_pkg SHALL hold:
- pixel24_t, a packed struct of r/g/b, each 8 bits;
- the FSM state enum;
- constant PIX_CH_W=8.
REQ-033 The FIFO SHALL be a sub-module yee_pixel_fifo (parameter DEPTH, push/pop/flush, count output), instantiated once; the averaging logic and FSM SHALL live in the top module.

Verification
REQ-034 After reset, push 24'h102030 then 24'h304050 with out_rdy=1 -> sub2_out_pixel=24'h203040 and sub2_out_vld=1 two cycles after the second push; this holds in both configurations.
REQ-035 Push 24'hFF0001 then 24'hFF0100:
- With the macro defined -> 24'hFF0101.
- With the macro undefined -> 24'hFF0000.
REQ-036 With out_rdy held at 0, push 2+DEPTH pixels (for DEPTH=4: 6 pixels, then a 7th offered) -> fifo_cnt=4 and sub2_rdy=0 after the 6th; ovf_sticky=1 after the 7th is offered; output held stable; nothing lost once out_rdy=1.
REQ-037 Push continuously for 16 pixels with out_rdy=1 -> 8 outputs in order, on every second cycle after the first, and fifo_cnt never exceeds 1.
REQ-038 Push one pixel, then assert flush (or pull reset low) for one cycle, then push a, b -> exactly one output, avg(a,b), and the stale first pixel is never used.
